muldiv_hilo: RTL and testbench

Parametrised HI/LO register pair with an integrated multi-cycle multiply/divide engine for the execute stage. It accepts one request at a time over a valid/ready handshake. Each request is one of: a direct HI/LO write, a multiply, a divide, or an optional multiply-accumulate. Results are committed to HI/LO atomically. In-flight operations can be flushed on exception or branch-mispredict without disturbing architectural HI/LO.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/div_iter.sv | 61 ++++++
 rtl/muldiv_hilo.sv | 169 ++++++++++++++++
 tb/tb_muldiv_hilo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the HI/LO multiply/divide unit.
//   muldiv_op_t    : request opcode (4-bit; encodings are fixed)
//   muldiv_state_t : control FSM state
//   dwidth()       : 2*WIDTH helper for full-product widths
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MTHI  = 4'd0,
    OP_MTLO  = 4'd1,
    OP_MULT  = 4'd2,
    OP_MULTU = 4'd3,
    OP_DIV   = 4'd4,
    OP_DIVU  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

  function automatic int dwidth(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: restoring radix-2 divider core on unsigned magnitudes.
//   clk, resetn        : clock, synchronous active-low reset
//   start              : load dividend/divisor, clear remainder
//   abort              : drop the current division
//   step               : perform one iteration (one quotient bit)
//   dividend, divisor  : WIDTH-bit magnitudes
//   quotient, remainder: results, valid after WIDTH steps
//   last               : high while the final step is being taken
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted, diff;

  // The quotient register doubles as the dividend shift register.
  assign shifted = {remainder, quotient[WIDTH-1]};
  // remainder < divisor holds between steps, so diff[WIDTH] is a clean borrow.
  assign diff    = shifted - {1'b0, dvs_q};
  assign last    = step && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      quotient  <= '0;
      remainder <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs_q     <= divisor;
      cnt_q     <= '0;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        remainder <= diff[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: HI/LO register pair with multi-cycle multiply/divide engine.
//   clk, resetn         : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE, no flush)
//   req_op, req_a, req_b: opcode and operands, latched at accept
//   flush               : abort in-flight op without touching HI/LO
//   busy                : FSM not idle
//   done                : one-cycle pulse when a multi-cycle result lands
//   hi, lo              : architectural registers
// Optional feature macro: MULDIV_ACC_EN builds MADD/MADDU/MSUB/MSUBU.
// Without it those opcodes are accepted and retire immediately as no-ops.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_t       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW = dwidth(WIDTH);
  localparam int CW = $clog2(MUL_LAT + 1);

  muldiv_state_t    state_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    prod_q;
  logic [DW-1:0]    mul_res;
  logic [WIDTH-1:0] a_q;
  logic             a_neg_q, q_neg_q, bz_q, done_q;
`ifdef MULDIV_ACC_EN
  muldiv_op_t       op_q;
`endif

  logic             accept, sgn_mul, sgn_div, is_div;
  logic [DW-1:0]    a_ext, b_ext, product;
  logic [WIDTH-1:0] a_mag, b_mag, div_q, div_r, q_fix, r_fix;
  logic             div_last;

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign accept    = req_valid && req_ready;

  assign sgn_mul = (req_op == OP_MULT) || (req_op == OP_MADD) || (req_op == OP_MSUB);
  assign sgn_div = (req_op == OP_DIV);
  assign is_div  = (req_op == OP_DIV) || (req_op == OP_DIVU);

  // Sign/zero extend to 2*WIDTH so one unsigned multiply covers both flavours.
  assign a_ext   = sgn_mul ? {{WIDTH{req_a[WIDTH-1]}}, req_a} : {{WIDTH{1'b0}}, req_a};
  assign b_ext   = sgn_mul ? {{WIDTH{req_b[WIDTH-1]}}, req_b} : {{WIDTH{1'b0}}, req_b};
  assign product = a_ext * b_ext;

  assign a_mag = (sgn_div && req_a[WIDTH-1]) ? -req_a : req_a;
  assign b_mag = (sgn_div && req_b[WIDTH-1]) ? -req_b : req_b;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept && is_div),
    .abort     (flush),
    .step      ((state_q == ST_DIV) && !flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .last      (div_last)
  );

  // MIN / -1 needs no special case: |MIN| / 1 = MIN, and negating MIN is MIN.
  assign q_fix = q_neg_q ? -div_q : div_q;
  assign r_fix = a_neg_q ? -div_r : div_r;

  // {hi,lo} is stable while busy, so reading it at commit equals reading at accept.
  always_comb begin
    mul_res = prod_q;
`ifdef MULDIV_ACC_EN
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod_q;
      OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod_q;
      default:           mul_res = prod_q;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      a_q     <= '0;
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULDIV_ACC_EN
      op_q    <= OP_MTHI;
`endif
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (accept) begin
            case (req_op)
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
`ifdef MULDIV_ACC_EN
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`else
              OP_MULT, OP_MULTU: begin
`endif
                state_q <= ST_MUL;
                cnt_q   <= CW'(MUL_LAT - 1);
                prod_q  <= product;
`ifdef MULDIV_ACC_EN
                op_q    <= req_op;
`endif
              end
              OP_DIV, OP_DIVU: begin
                state_q <= ST_DIV;
                a_q     <= req_a;
                bz_q    <= (req_b == '0);
                a_neg_q <= sgn_div && req_a[WIDTH-1];
                q_neg_q <= sgn_div && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
              end
              default: ;
            endcase
          end
          ST_MUL: begin
            if (cnt_q == '0) begin
              {hi, lo} <= mul_res;
              done_q   <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_DIV: if (div_last) state_q <= ST_FIX;
          ST_FIX: begin
            if (bz_q) begin
              lo <= '1;
              hi <= a_q;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed self-checking bench for muldiv_hilo.
// Expectations follow MULDIV_ACC_EN so the bench suits either build.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic             req_valid;
  logic             req_ready;
  muldiv_op_t       req_op;
  logic [WIDTH-1:0] req_a, req_b;
  logic             flush;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic seen_done;

  muldiv_hilo #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; operands are scrambled afterwards to prove latching.
  task automatic issue(input muldiv_op_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    step();
    req_valid = 1'b0;
    req_a     = 32'hDEADBEEF;
    req_b     = 32'h13579BDF;
  endtask

  // Called just after the accept edge; done must rise exactly n edges later.
  task automatic wait_commit(input int n, input string tag);
    for (int i = 1; i < n; i++) begin
      step();
      chk({tag, "_early"}, 64'(done), 64'd0);
    end
    step();
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = OP_MTHI;
    req_a = '0; req_b = '0; flush = 1'b0; seen_done = 1'b0;
    step(); step();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    resetn = 1'b1;

    // Back-to-back MTHI/MTLO
    issue(OP_MTHI, 32'h1234, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_done", 64'(done), 64'd0);
    chk("mthi_ready", 64'(req_ready), 64'd1);
    issue(OP_MTLO, 32'hABCD, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'hABCD);
    chk("mtlo_hi", 64'(hi), 64'h1234);
    chk("mtlo_done", 64'(done), 64'd0);

    // Multiply
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
    chk("mult_busy", 64'(busy), 64'd1);
    chk("mult_ready", 64'(req_ready), 64'd0);
    wait_commit(MUL_LAT, "mult");
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    chk("mult_ready_done", 64'(req_ready), 64'd1);
    step();
    chk("mult_done_fall", 64'(done), 64'd0);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_commit(MUL_LAT, "multu");
    chk("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

    // Divide
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_busy", 64'(busy), 64'd1);
    wait_commit(WIDTH + 1, "div");
    chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_commit(WIDTH + 1, "divz");
    chk("divz_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_commit(WIDTH + 1, "divovf");
    chk("divovf_hilo", {hi, lo}, 64'h00000000_80000000);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_commit(WIDTH + 1, "divu");
    chk("divu_hilo", {hi, lo}, 64'h00000002_0000000E);

    // Accumulate
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MADDU, 32'd3, 32'd4);
`ifdef MULDIV_ACC_EN
    chk("maddu_busy", 64'(busy), 64'd1);
    wait_commit(MUL_LAT, "maddu");
    chk("maddu_hilo", {hi, lo}, 64'd17);
    issue(OP_MSUB, 32'd1, 32'd18);
    wait_commit(MUL_LAT, "msub");
    chk("msub_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
`else
    chk("maddu_busy", 64'(busy), 64'd0);
    chk("maddu_done", 64'(done), 64'd0);
    chk("maddu_hilo", {hi, lo}, 64'd5);
    issue(OP_MSUB, 32'd1, 32'd18);
    chk("msub_busy", 64'(busy), 64'd0);
    chk("msub_ready", 64'(req_ready), 64'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || busy) seen_done = 1'b1;
    end
    chk("msub_quiet", 64'(seen_done), 64'd0);
    chk("msub_hilo", {hi, lo}, 64'd5);
`endif

    // Flush mid-divide
    issue(OP_MTHI, 32'hAAAA, 32'd0);
    issue(OP_MTLO, 32'h5555, 32'd0);
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    #1;
    chk("flush_ready_low", 64'(req_ready), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_ready", 64'(req_ready), 64'd1);
    chk("flush_hilo", {hi, lo}, 64'h0000AAAA_00005555);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("flush_no_done", 64'(seen_done), 64'd0);
    chk("flush_hilo_late", {hi, lo}, 64'h0000AAAA_00005555);

    // Flush with a request in IDLE: nothing accepted
    flush = 1'b1; req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'h77;
    #1;
    chk("flush_idle_ready", 64'(req_ready), 64'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush_idle_hi", 64'(hi), 64'hAAAA);
    chk("flush_idle_busy", 64'(busy), 64'd0);

    // Reset mid-divide
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (4) step();
    chk("rstmid_busy_pre", 64'(busy), 64'd1);
    resetn = 1'b0;
    step();
    chk("rstmid_hilo", {hi, lo}, 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    resetn = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) seen_done = 1'b1;
    end
    chk("rstmid_quiet", 64'(seen_done), 64'd0);
    chk("rstmid_hilo_late", {hi, lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
